// File: rtl/clkhf_sequencer_if.sv
// PMU <-> oscillator sequencer signal bundle.
// The PMU side drives the requests and the sequencer drives the pins and status.
interface clkhf_sequencer_if;
  logic        clkhf_powerup;
  logic        clkhf_enable;
  logic        osc_pu;
  logic        osc_en;
  logic        clk_ready;
  logic [2:0]  pwr_state;
  logic [15:0] pu_count;

  modport master (
    output clkhf_powerup, clkhf_enable,
    input  osc_pu, osc_en, clk_ready, pwr_state, pu_count
  );

  modport slave (
    input  clkhf_powerup, clkhf_enable,
    output osc_pu, osc_en, clk_ready, pwr_state, pu_count
  );
endinterface

// File: rtl/clkhf_sequencer.sv
// SB_HFOSC power/enable sequencer on the always-on slow clock.
// Enforces settle, drain and minimum-off times and reports when the fast clock is usable.
module clkhf_sequencer #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned PU_DELAY = 4,
  parameter int unsigned EN_DELAY = 2,
  parameter int unsigned DRAIN    = 2,
  parameter int unsigned OFF_MIN  = 3
) (
  input  logic             slow_clk,
  input  logic             rst_n,
  clkhf_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_PWRUP   = 3'd1,
    S_STANDBY = 3'd2,
    S_ENWAIT  = 3'd3,
    S_RUN     = 3'd4,
    S_DRAINST = 3'd5,
    S_PWRDN   = 3'd6
  } state_e;

  localparam logic [CNT_W-1:0] PU_LOAD    = CNT_W'(PU_DELAY - 1);
  localparam logic [CNT_W-1:0] EN_LOAD    = CNT_W'(EN_DELAY - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD   = CNT_W'(OFF_MIN - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      pu_cnt_q;
  logic             pu_q, en_q, rdy_q;
  logic             pu_d, en_d, rdy_d;
  logic             inc;
  logic             en_req;

  assign en_req = bus.clkhf_enable & bus.clkhf_powerup;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inc     = 1'b0;
    case (state_q)
      S_OFF: begin
        if (bus.clkhf_powerup) begin
          state_d = S_PWRUP;
          cnt_d   = PU_LOAD;
          inc     = 1'b1;
        end
      end
      // A power-up abort outranks settle completion so the pin drops on the next edge.
      S_PWRUP: begin
        if (!bus.clkhf_powerup) begin
          state_d = S_PWRDN;
          cnt_d   = OFF_LOAD;
        end else if (cnt_q == '0) begin
          state_d = S_STANDBY;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_STANDBY: begin
        if (!bus.clkhf_powerup) begin
          state_d = S_PWRDN;
          cnt_d   = OFF_LOAD;
        end else if (en_req) begin
          state_d = S_ENWAIT;
          cnt_d   = EN_LOAD;
        end
      end
      S_ENWAIT: begin
        if (!en_req) begin
          state_d = S_STANDBY;
        end else if (cnt_q == '0) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RUN: begin
        if (!en_req) begin
          state_d = S_DRAINST;
          cnt_d   = DRAIN_LOAD;
        end
      end
      S_DRAINST: begin
        if (cnt_q == '0) state_d = S_STANDBY;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_PWRDN: begin
        if (cnt_q == '0) state_d = S_OFF;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: begin
        state_d = S_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  // Pin levels are decoded from the next state so they register alongside it.
  always_comb begin
    pu_d  = 1'b0;
    en_d  = 1'b0;
    rdy_d = 1'b0;
    case (state_d)
      S_PWRUP, S_STANDBY:  pu_d = 1'b1;
      S_ENWAIT, S_DRAINST: begin
        pu_d = 1'b1;
        en_d = 1'b1;
      end
      S_RUN: begin
        pu_d  = 1'b1;
        en_d  = 1'b1;
        rdy_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge slow_clk) begin
    if (!rst_n) begin
      state_q  <= S_OFF;
      cnt_q    <= '0;
      pu_q     <= 1'b0;
      en_q     <= 1'b0;
      rdy_q    <= 1'b0;
      pu_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pu_q    <= pu_d;
      en_q    <= en_d;
      rdy_q   <= rdy_d;
      if (inc && (pu_cnt_q != '1)) pu_cnt_q <= pu_cnt_q + 16'd1;
    end
  end

  assign bus.osc_pu    = pu_q;
  assign bus.osc_en    = en_q;
  assign bus.clk_ready = rdy_q;
  assign bus.pwr_state = state_q;
  assign bus.pu_count  = pu_cnt_q;

endmodule

// File: tb/tb_clkhf_sequencer.sv
// Directed scoreboard bench for clkhf_sequencer with default timing parameters.
module tb_clkhf_sequencer;

  logic slow_clk = 1'b0;
  logic rst_n    = 1'b0;

  always #5 slow_clk = ~slow_clk;

  clkhf_sequencer_if bus();

  clkhf_sequencer #(
    .CNT_W(16), .PU_DELAY(4), .EN_DELAY(2), .DRAIN(2), .OFF_MIN(3)
  ) dut (
    .slow_clk(slow_clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned nvec  = 0;
  int unsigned nfail = 0;

  // Pin levels {osc_pu, osc_en, clk_ready} of each state.
  function automatic logic [2:0] pins(input logic [2:0] s);
    case (s)
      3'd1, 3'd2: return 3'b100;
      3'd3, 3'd5: return 3'b110;
      3'd4:       return 3'b111;
      default:    return 3'b000;
    endcase
  endfunction

  // Drive inputs for n edges and expect state s and count c after each edge.
  task automatic step(input logic r, input logic p, input logic e,
                      input logic [2:0] s, input logic [15:0] c,
                      input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge slow_clk);
      rst_n             = r;
      bus.clkhf_powerup = p;
      bus.clkhf_enable  = e;
      exp_q.push_back('{st: s, cnt: c});
    end
  endtask

  initial begin : monitor
    exp_t       ex;
    logic [2:0] act_pins;
    forever begin
      @(posedge slow_clk);
      #1;
      if (exp_q.size() > 0) begin
        ex       = exp_q.pop_front();
        act_pins = {bus.osc_pu, bus.osc_en, bus.clk_ready};
        nvec++;
        if (bus.pwr_state !== ex.st) begin
          nfail++;
          $display("FAIL pwr_state @%0t: got %0d expected %0d", $time, bus.pwr_state, ex.st);
        end
        nvec++;
        if (act_pins !== pins(ex.st)) begin
          nfail++;
          $display("FAIL pins(pu,en,rdy) @%0t: got %b expected %b", $time, act_pins, pins(ex.st));
        end
        nvec++;
        if (bus.pu_count !== ex.cnt) begin
          nfail++;
          $display("FAIL pu_count @%0t: got %h expected %h", $time, bus.pu_count, ex.cnt);
        end
        nvec++;
        if (bus.osc_en && !bus.osc_pu) begin
          nfail++;
          $display("FAIL inv_en_pu @%0t: got osc_en=1 osc_pu=0 expected osc_pu=1", $time);
        end
        nvec++;
        if (bus.clk_ready && !bus.osc_en) begin
          nfail++;
          $display("FAIL inv_rdy_en @%0t: got clk_ready=1 osc_en=0 expected osc_en=1", $time);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    bus.clkhf_powerup = 1'b0;
    bus.clkhf_enable  = 1'b0;

    // Reset held with both requests high, then full power-up and enable.
    step(1'b0, 1'b1, 1'b1, 3'd0, 16'd0, 2);
    step(1'b1, 1'b1, 1'b1, 3'd1, 16'd1, 4);
    step(1'b1, 1'b1, 1'b1, 3'd2, 16'd1);
    step(1'b1, 1'b1, 1'b1, 3'd3, 16'd1, 2);
    step(1'b1, 1'b1, 1'b1, 3'd4, 16'd1, 3);

    // Enable drop in RUN: ready falls first, osc_en two edges later.
    step(1'b1, 1'b1, 1'b0, 3'd5, 16'd1, 2);
    step(1'b1, 1'b1, 1'b0, 3'd2, 16'd1, 2);

    // One-cycle enable pulse aborts ENWAIT.
    step(1'b1, 1'b1, 1'b1, 3'd3, 16'd1);
    step(1'b1, 1'b1, 1'b0, 3'd2, 16'd1, 2);

    // Power-up drop in RUN drains first, then powers down from STANDBY.
    step(1'b1, 1'b1, 1'b1, 3'd3, 16'd1, 2);
    step(1'b1, 1'b1, 1'b1, 3'd4, 16'd1);
    step(1'b1, 1'b0, 1'b1, 3'd5, 16'd1, 2);
    step(1'b1, 1'b0, 1'b1, 3'd2, 16'd1);
    step(1'b1, 1'b0, 1'b1, 3'd6, 16'd1, 3);

    // Enable alone never wakes the oscillator.
    step(1'b1, 1'b0, 1'b1, 3'd0, 16'd1, 4);

    // Abort two edges into PWRUP, reassert at once: minimum off time applies.
    step(1'b1, 1'b1, 1'b0, 3'd1, 16'd2, 2);
    step(1'b1, 1'b0, 1'b0, 3'd6, 16'd2);
    step(1'b1, 1'b1, 1'b0, 3'd6, 16'd2, 2);
    step(1'b1, 1'b1, 1'b0, 3'd0, 16'd2);
    step(1'b1, 1'b1, 1'b0, 3'd1, 16'd3, 4);
    step(1'b1, 1'b1, 1'b0, 3'd2, 16'd3);

    // Saturation: preload the counter one below max while idle.
    step(1'b1, 1'b0, 1'b0, 3'd6, 16'd3, 3);
    step(1'b1, 1'b0, 1'b0, 3'd0, 16'd3);
    @(posedge slow_clk);
    #2;
    force dut.pu_cnt_q = 16'hFFFE;
    step(1'b1, 1'b0, 1'b0, 3'd0, 16'hFFFE);
    @(posedge slow_clk);
    #2;
    release dut.pu_cnt_q;
    step(1'b1, 1'b1, 1'b0, 3'd1, 16'hFFFF);
    step(1'b1, 1'b0, 1'b0, 3'd6, 16'hFFFF, 3);
    step(1'b1, 1'b0, 1'b0, 3'd0, 16'hFFFF);
    step(1'b1, 1'b1, 1'b0, 3'd1, 16'hFFFF);
    step(1'b1, 1'b0, 1'b0, 3'd6, 16'hFFFF, 3);
    step(1'b1, 1'b0, 1'b0, 3'd0, 16'hFFFF);

    // Reset in RUN drops everything at once with no drain.
    step(1'b1, 1'b1, 1'b1, 3'd1, 16'hFFFF, 4);
    step(1'b1, 1'b1, 1'b1, 3'd2, 16'hFFFF);
    step(1'b1, 1'b1, 1'b1, 3'd3, 16'hFFFF, 2);
    step(1'b1, 1'b1, 1'b1, 3'd4, 16'hFFFF);
    step(1'b0, 1'b1, 1'b1, 3'd0, 16'd0);

    repeat (2) @(posedge slow_clk);
    #3;
    nvec++;
    if (exp_q.size() != 0) begin
      nfail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
